// File: rtl/ysyx_25030093_wbu.sv
// Write-back unit: latches one LSU result, writes the GPR file, then holds the commit until the IFU takes it.
// Optional macro WBU_BYPASS_EN forwards the pending write data to rs1/rs2 reads while in WRITE.
module ysyx_25030093_wbu #(
    parameter int REG_NUM = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        out_ready,
    output logic        out_valid,
    input  logic        in_ready,
    input  logic [1:0]  wb_sel,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    input  logic [31:0] LSU_data,
    input  logic [31:0] pc,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] commit_pc,
    output logic [31:0] retire_cnt
);

    // state | meaning
    // IDLE  | ready for a result from the LSU
    // WRITE | captured result is written to the GPR file at the next edge
    // DONE  | commit info valid, waiting for in_ready
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] gpr_q [REG_NUM];
    logic [31:0] gpr_d [REG_NUM];
    logic        wen;

    assign wen        = (sel_q != 2'b11) && (rd_q != 5'd0) && (int'(rd_q) < REG_NUM);
    assign commit_pc  = pc_q;
    assign retire_cnt = cnt_q;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        pc_d      = pc_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        gpr_d     = gpr_q;
        out_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                out_ready = 1'b1;
                if (in_valid) begin
                    rd_d  = rd_addr;
                    pc_d  = pc;
                    sel_d = wb_sel;
                    case (wb_sel)
                        2'b00:   wdata_d = rd_data;
                        2'b01:   wdata_d = LSU_data;
                        2'b10:   wdata_d = pc + 32'd4;
                        default: wdata_d = 32'd0;
                    endcase
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wen) gpr_d[rd_q] = wdata_q;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (in_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        if (rs1_addr != 5'd0 && int'(rs1_addr) < REG_NUM) rs1_data = gpr_q[rs1_addr];
        if (rs2_addr != 5'd0 && int'(rs2_addr) < REG_NUM) rs2_data = gpr_q[rs2_addr];
`ifdef WBU_BYPASS_EN
        // Forward the write that lands at the end of this cycle.
        if (state_q == WRITE && wen && rs1_addr == rd_q) rs1_data = wdata_q;
        if (state_q == WRITE && wen && rs2_addr == rd_q) rs2_data = wdata_q;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            rd_q    <= 5'd0;
            pc_q    <= 32'd0;
            sel_q   <= 2'b11;
            wdata_q <= 32'd0;
            cnt_q   <= 32'd0;
            for (int i = 0; i < REG_NUM; i++) gpr_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            gpr_q   <= gpr_d;
        end
    end

endmodule

// File: doc/ysyx_25030093_wbu.md
YSYX_25030093_WBU -- requirements
Module: ysyx_25030093_WBU

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural GPRs; x0 is hardwired to zero.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low: the block is in reset while reset==0 at a posedge.
REQ-004 SHALL have port in_valid, input, 1, upstream (LSU) result valid.
REQ-005 SHALL have port out_ready, output, 1, WBU can accept a result.
REQ-006 SHALL have port out_valid, output, 1, instruction retired; commit info valid.
REQ-007 SHALL have port in_ready, input, 1, downstream (IFU) ready to take the commit.
REQ-008 SHALL have port wb_sel, input, 2, source select: 00 rd_data (ALU), 01 LSU_data, 10 pc+4, 11 no write.
REQ-009 SHALL have ports rd_addr (input, 5, destination reg), rd_data (input, 32, ALU result), LSU_data (input, 32, load result) and pc (input, 32, instruction PC).
REQ-010 SHALL have ports rs1_addr and rs2_addr (input, 5 each) and rs1_data and rs2_data (output, 32 each, combinational GPR reads).
REQ-011 SHALL have ports commit_pc (output, 32, PC of retired instruction) and retire_cnt (output, 32, retired instruction count).

Function
REQ-012 SHALL implement FSM IDLE -> WRITE -> DONE -> IDLE; out_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-013 IDLE: on in_valid&out_ready at a posedge, SHALL latch rd_addr, pc, wb_sel and the selected write data, then go to WRITE; without in_valid, SHALL stay in IDLE.
REQ-014 Write data SHALL be rd_data (wb_sel 00), LSU_data (01) or pc+32'd4 mod 2^32 (10); it is captured in IDLE, so later input changes SHALL NOT affect it.
REQ-015 WRITE: SHALL write the GPR at the posedge leaving WRITE iff latched wb_sel!=11 and latched rd_addr!=0, then go to DONE unconditionally.
REQ-016 rs1_data/rs2_data SHALL return 0 for address 0, otherwise the stored value; without bypass, a read during WRITE of the pending rd SHALL return the old value.
REQ-017 DONE: SHALL hold out_valid and commit_pc stable until in_ready; on in_ready at a posedge, SHALL go to IDLE and increment retire_cnt by 1, wrapping from 32'hFFFFFFFF to 0.
REQ-018 Latency: a result accepted at edge N SHALL be written at edge N+1, readable from cycle N+1 onward, with out_valid high from cycle N+1; minimum throughput is one instruction per 3 cycles.
REQ-019 in_valid while not in IDLE SHALL be ignored, with no capture and no state change.
REQ-020 Illegal FSM encodings SHALL return to IDLE on the next posedge.

Reset
REQ-021 While reset==0 at a posedge: state=IDLE, out_valid=0, out_ready=1 after release, commit_pc=0, retire_cnt=0, all GPRs=0.
REQ-022 Reset SHALL override every transition; asserting reset in WRITE SHALL suppress the pending GPR write, and asserting it in DONE SHALL drop the commit with no count increment.

Configuration
REQ-023 Macro WBU_BYPASS_EN defined: in WRITE state, an rs1/rs2 read matching a pending nonzero rd with wb_sel!=11 SHALL return the pending write data.
REQ-024 Macro WBU_BYPASS_EN undefined: SHALL have no bypass logic, and reads SHALL behave per REQ-016.

Verification
REQ-025 Reset, then wb_sel=00, rd_addr=5, rd_data=32'h1234_5678, one in_valid pulse, in_ready=1 -> x5=32'h12345678 from cycle N+1; out_valid high for exactly 1 cycle; retire_cnt=1.
REQ-026 wb_sel=10, pc=32'hFFFF_FFFC, rd_addr=1 -> x1 reads 32'h0000_0000 (wrap); wb_sel=01, LSU_data=32'hDEAD_BEEF, rd_addr=2 -> x2=32'hDEADBEEF.
REQ-027 rd_addr=0 with wb_sel=00 and data 32'hFFFFFFFF, plus a separate case with wb_sel=11 and rd_addr=3 -> x0 reads 0 and x3 is unchanged; both still commit, so retire_cnt advances by 2.
REQ-028 in_ready=0 for 4 cycles in DONE -> out_valid and commit_pc held stable, out_ready=0, extra in_valid pulses ignored; on in_ready=1 the FSM returns to IDLE next cycle.
REQ-029 Drive reset=0 during WRITE with rd_addr=7 and data 32'hA5A5A5A5 -> x7 reads 0 and retire_cnt=0 after reset release.
REQ-030 With WBU_BYPASS_EN defined, rs1_addr=rd_addr=9 during WRITE with data 32'h55 -> rs1_data=32'h55 in that cycle; with it undefined -> rs1_data returns the old value.
